// File: rtl/shifter_pkg.sv
// Shared widths, FSM state encodings and shift-amount clamp for the multi-cycle right shifter.
package shifter_pkg;

    localparam int unsigned SH_W   = 12;
    localparam int unsigned SH_SHW = 4;

    localparam int unsigned ST_BITS = 2;
    typedef logic [ST_BITS-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Amounts at or beyond the operand width shift every bit out, so they collapse to the width.
    function automatic int unsigned clamp_amt(input int unsigned amt, input int unsigned width);
        return (amt >= width) ? width : amt;
    endfunction

endpackage

// File: rtl/rightshifter1.sv
// Combinational one-position right shift: fill bit enters at the MSB, LSB leaves as bitout.
module rightshifter1 #(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] i_in,
    input  logic         i_fill,
    output logic [W-1:0] o_out_c,
    output logic         o_bitout_c
);

    assign o_out_c    = {i_fill, i_in[W-1:1]};
    assign o_bitout_c = i_in[0];

endmodule

// File: rtl/rightshifter_seq.sv
// Multi-cycle logical/arithmetic right shifter, one bit per clock, with start/busy/done handshake.
module rightshifter_seq
    import shifter_pkg::*;
#(
    parameter int unsigned W   = SH_W,
    parameter int unsigned SHW = SH_SHW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic [W-1:0]   i_in,
    input  logic [SHW-1:0] i_shamt,
    input  logic           i_arith,
    output logic           o_busy,
    output logic           o_done,
    output logic [W-1:0]   o_out,
    output logic           o_cout
);

    localparam int unsigned CNTW = $clog2(W + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_busy;
    logic            r_done;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_load;
    logic            w_step;

    logic [W-1:0]    r_reg;
    logic            r_fill;
    logic            r_cout;
    logic [CNTW-1:0] r_count;

    logic            w_ready;
    logic            w_accept;
    logic [CNTW-1:0] w_n;
    logic [W-1:0]    w_shift;
    logic            w_bitout;

    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept = w_ready && i_start;
    assign w_n      = CNTW'(clamp_amt(32'(i_shamt), W));

    rightshifter1 #(
        .W (W)
    ) u_step (
        .i_in       (r_reg),
        .i_fill     (r_fill),
        .o_out_c    (w_shift),
        .o_bitout_c (w_bitout)
    );

    // State register; busy/done are registered alongside so the outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; a start seen in SHIFT is deliberately not looked at.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = (w_n == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_count == CNTW'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/control decode.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_busy_nxt = (w_state_nxt == ST_SHIFT);
        w_done_nxt = (w_state_nxt == ST_DONE);
        w_load     = w_accept;
        w_step     = (r_state == ST_SHIFT);
    end

    // Datapath: operand register, fill bit, down-counter and carry-out flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg   <= '0;
            r_fill  <= 1'b0;
            r_cout  <= 1'b0;
            r_count <= '0;
        end else if (w_load) begin
            r_reg   <= i_in;
            r_fill  <= i_arith & i_in[W-1];
            r_cout  <= 1'b0;
            r_count <= w_n;
        end else if (w_step) begin
            r_reg   <= w_shift;
            r_cout  <= w_bitout;
            r_count <= r_count - CNTW'(1);
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_out  = r_reg;
    assign o_cout = r_cout;

endmodule

// File: tb/tb_rightshifter_seq.sv
// Scoreboard bench for rightshifter_seq: stimulus pushes expected results, a monitor checks done pulses.
module tb_rightshifter_seq;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [11:0] i_in;
    logic [3:0]  i_shamt;
    logic        i_arith;
    logic        o_busy;
    logic        o_done;
    logic [11:0] o_out;
    logic        o_cout;

    typedef struct {
        logic [11:0] out;
        logic        cout;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    bit   mon_en  = 0;
    bit   saw_done = 0;

    rightshifter_seq #(.W(12), .SHW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_in    (i_in),
        .i_shamt (i_shamt),
        .i_arith (i_arith),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_out   (o_out),
        .o_cout  (o_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (mon_en && o_done) begin
            saw_done = 1;
            chk("busy_done_excl", 32'(o_busy), 32'd0);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_out", 32'(o_out), 32'(e.out));
                chk("result_cout", 32'(o_cout), 32'(e.cout));
                chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    // Called at posedge+1; accepted on the next edge, then inputs are scrambled.
    task automatic issue(input logic [11:0] a, input logic [3:0] s, input logic ar,
                         input logic [11:0] eo, input logic ec, input bit push);
        int n;
        i_start = 1'b1;
        i_in    = a;
        i_shamt = s;
        i_arith = ar;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_in    = a ^ 12'hA5A;
        i_shamt = ~s;
        i_arith = ~ar;
        n = (int'(s) >= 12) ? 12 : int'(s);
        if (push) sb.push_back('{out: eo, cout: ec, done_cyc: cyc + n});
    endtask

    task automatic wait_idle();
        int w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL done_timeout: got %0d pending ops expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_in    = '0;
        i_shamt = '0;
        i_arith = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_out", 32'(o_out), 32'd0);
        chk("rst_cout", 32'(o_cout), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;
        @(posedge clk);
        #1;

        issue(12'd24,   4'd1,  1'b0, 12'd12,  1'b0, 1); wait_idle();
        issue(12'h800,  4'd3,  1'b1, 12'hF00, 1'b0, 1); wait_idle();

        issue(12'h0F3,  4'd0,  1'b0, 12'h0F3, 1'b0, 1);
        chk("zero_amt_busy", 32'(o_busy), 32'd0);
        chk("zero_amt_done", 32'(o_done), 32'd1);
        wait_idle();

        issue(12'hFFF,  4'd15, 1'b0, 12'h000, 1'b1, 1); wait_idle();
        issue(12'hFFF,  4'd15, 1'b1, 12'hFFF, 1'b1, 1); wait_idle();
        issue(12'h5A5,  4'd3,  1'b0, 12'h0B4, 1'b1, 1); wait_idle();
        issue(12'hA5A,  4'd5,  1'b1, 12'hFD2, 1'b1, 1); wait_idle();

        // Start pulsed mid-shift with a different operand must be ignored.
        issue(12'h0C8,  4'd4,  1'b0, 12'h00C, 1'b1, 1);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_in    = 12'hFFF;
        i_shamt = 4'd1;
        i_arith = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        chk("midshift_busy", 32'(o_busy), 32'd1);
        wait_idle();

        // Back-to-back: second start held during the DONE cycle of the first.
        issue(12'h100,  4'd2,  1'b0, 12'h040, 1'b0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b_done_cycle", 32'(o_done), 32'd1);
        issue(12'h007,  4'd1,  1'b0, 12'h003, 1'b1, 1);
        wait_idle();

        // Reset two edges into a 5-bit shift: immediate clear and no done afterwards.
        issue(12'h123,  4'd5,  1'b0, 12'h000, 1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        saw_done = 0;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_done", 32'(o_done), 32'd0);
        chk("midrst_out", 32'(o_out), 32'd0);
        chk("midrst_cout", 32'(o_cout), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_after_rst", 32'(saw_done), 32'd0);
        chk("idle_after_rst", 32'(o_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
